layer_input_packer: RTL and testbench
=====================================

# layer_input_packer

Feeds one `Layer` instance from a serial sample stream. It accepts `INPUT_NUM` fixed-point samples one per handshake and converts each to the layer's input format. It then presents them as the packed `x` bus with a one-cycle `valid` pulse, and holds off further input until the layer reports completion. It sits at the input side of every layer: between the sample source or previous-stage serializer and `Layer.valid`/`Layer.x`, with `Layer.out_ready` returned as `layer_done`.

## Interface
- `INPUT_NUM`, 2: samples per packed vector; must match the driven layer.
- `IN_WIDTH`, 16: width of each packed element.
- `IN_FRACTION`, 14: fraction bits of each packed element.
- `S_WIDTH`, 24: width of incoming samples.
- `S_FRACTION`, 16: fraction bits of incoming samples; must satisfy S_FRACTION >= IN_FRACTION.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `s_valid`  in  1  sample available.
- `s_ready`  out  1  packer can accept a sample.
- `s_data`  in  S_WIDTH  signed sample, S_FRACTION fraction bits.
- `x`  out  IN_WIDTH*INPUT_NUM  packed vector; element k at x[k*IN_WIDTH +: IN_WIDTH], k=0 is the first sample accepted.
- `valid`  out  1  one-cycle pulse, vector on `x` is new; connect to `Layer.valid`.
- `layer_done`  in  1  `Layer.out_ready`.
- `count`  out  $clog2(INPUT_NUM+1)  samples held in the fill buffer.
- `busy`  out  1  high in ISSUE or WAIT.
- `sat`  out  1  one-cycle pulse when an accepted sample was saturated.

## Operation
- Registers:
  - fill buffer of INPUT_NUM elements;
  - output register driving `x`;
  - `count`;
  - `done_q`, the previous-cycle value of `layer_done`;
  - a 2-bit state register.
- FILL state:
  - `s_ready` = 1.
  - On handshake (s_valid & s_ready), the converted sample is written to fill element `count`, and `count` increments.
  - On the handshake that fills element INPUT_NUM-1, the whole buffer, including that sample, is copied to `x`; `count` goes to 0 and the state goes to ISSUE.
- ISSUE state:
  - `valid` = 1 and `s_ready` = 0 for exactly one cycle, then the state goes to WAIT.
- WAIT state:
  - `s_ready` = 0.
  - Leaves for FILL on the first cycle where layer_done & ~done_q (rising edge).
  - A level-high `layer_done` with no rising edge is ignored.
  - Rising edges in FILL or ISSUE are ignored.
- `x` changes only on the copy into ISSUE and is stable at all other times, including throughout the following FILL.
- Conversion:
  - Arithmetic right shift of `s_data` by S_FRACTION-IN_FRACTION, truncating toward minus infinity.
  - Then reduction to IN_WIDTH bits according to Configuration.
  - When S_FRACTION equals IN_FRACTION, there is no shift.
- `busy` = (state == ISSUE) | (state == WAIT).

## Timing
- Reset values:
  - `x` = 0, `valid` = 0, `count` = 0, `sat` = 0, `busy` = 0, `done_q` = 0.
  - The state is FILL, so `s_ready` = 1 once rst_n is high.
- Reset mid-operation: all registers clear immediately; partial fill and pending WAIT are discarded.
- Latency:
  - Final sample handshake at edge t: `x` is updated and `valid` is high in cycle t+1; the state is WAIT from t+2.
  - A rising edge of `layer_done` sampled at edge u in WAIT puts the state in FILL, with `s_ready` = 1, from u+1.
- Minimum spacing between `valid` pulses: INPUT_NUM+2 cycles.
- `s_ready` is a function of state only; it never depends combinationally on `s_valid`.
- `sat` is registered and aligned to the cycle after the saturating handshake.

## Configuration
- `LAYER_PACKER_SATURATE_EN` defined:
  - The shifted value is clamped to [-2^(IN_WIDTH-1), 2^(IN_WIDTH-1)-1].
  - `sat` pulses when a clamp occurs.
- Not defined:
  - The low IN_WIDTH bits of the shifted value are taken, so the value wraps.
  - `sat` is tied to 0.

## Test plan
All scenarios use defaults (INPUT_NUM=2, IN 16/14, S 24/16).
- Reset then idle: rst_n low mid-FILL with count=1 -> count=0, x=0, valid=0, s_ready=1 on release; next two samples fill elements 0 and 1.
- Samples 0x010000 (1.0) and 0xFF0000 (-1.0), back-to-back -> valid is one cycle, the cycle after the second handshake, with x=0xC000_4000; s_ready is 0 from that cycle.
- While in WAIT, hold layer_done at 1 from before ISSUE -> stays in WAIT; drop to 0 then raise -> FILL one cycle after the rising edge; x unchanged throughout.
- With `s_valid` held at 1 continuously and layer_done pulsed 3 cycles after each valid -> valid pulses every 6 cycles; no sample lost or duplicated (check with an incrementing pattern).
- With the macro defined, sample 0x030000 (3.0) -> element 0x7FFF and sat=1; sample 0xFD0000 (-3.0) -> 0x8000 and sat=1.
- Without the macro, same samples -> 0xC000 and 0x4000, sat=0.
- Sample 0x000003 -> element 0x0000; sample 0xFFFFFF -> element 0xFFFF (floor truncation).

Source files
------------

// File: rtl/layer_input_packer.sv
// layer_input_packer
//
// Purpose:
//    Collects INPUT_NUM serial fixed-point samples and converts each one to the
//    layer input format. It then presents them to a Layer as one packed vector
//    with a single-cycle valid pulse. No further samples are accepted until the
//    layer signals completion with a rising edge on layer_done.
//
// Configuration macro:
//    LAYER_PACKER_SATURATE_EN - when defined, converted samples are clamped to the
//    IN_WIDTH signed range and sat pulses on a clamp. When undefined, the low
//    IN_WIDTH bits are kept (wrap-around) and sat is always 0.
//
// Ports:
//    clk         in   single clock, rising edge
//    rst_n       in   asynchronous active-low reset
//    s_valid     in   sample available
//    s_ready     out  packer accepts a sample (FILL state only)
//    s_data      in   signed sample, S_FRACTION fraction bits
//    x           out  packed vector, element k at x[k*IN_WIDTH +: IN_WIDTH]
//    valid       out  one-cycle pulse: x holds a new vector
//    layer_done  in   Layer.out_ready
//    count       out  samples currently held in the fill buffer
//    busy        out  high while issuing or waiting for the layer
//    sat         out  one-cycle pulse: the previous accepted sample was clamped
module layer_input_packer #(
   parameter int INPUT_NUM   = 2,
   parameter int IN_WIDTH    = 16,
   parameter int IN_FRACTION = 14,
   parameter int S_WIDTH     = 24,
   parameter int S_FRACTION  = 16
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              s_valid,
   output logic                              s_ready,
   input  logic [S_WIDTH-1:0]                s_data,
   output logic [IN_WIDTH*INPUT_NUM-1:0]     x,
   output logic                              valid,
   input  logic                              layer_done,
   output logic [$clog2(INPUT_NUM+1)-1:0]    count,
   output logic                              busy,
   output logic                              sat
);

   localparam int CNT_W = $clog2(INPUT_NUM + 1);
   localparam int SHIFT = S_FRACTION - IN_FRACTION;
   // One guard bit above the wider of the two formats keeps the clamp compare exact.
   localparam int EW    = ((S_WIDTH > IN_WIDTH) ? S_WIDTH : IN_WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(INPUT_NUM - 1);

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t                          state;
   logic                            done_q;
   logic [IN_WIDTH-1:0]             fill [INPUT_NUM];
   logic [IN_WIDTH*INPUT_NUM-1:0]   vec_next;

   logic signed [EW-1:0]            s_ext;
   logic signed [EW-1:0]            shifted;
   logic [IN_WIDTH-1:0]             conv;
   logic                            conv_sat;

   // Sign-extend first so the arithmetic shift floors toward minus infinity.
   assign s_ext   = EW'($signed(s_data));
   assign shifted = s_ext >>> SHIFT;

`ifdef LAYER_PACKER_SATURATE_EN
   localparam logic signed [EW-1:0] MAX_V = {{(EW-IN_WIDTH+1){1'b0}}, {(IN_WIDTH-1){1'b1}}};
   localparam logic signed [EW-1:0] MIN_V = {{(EW-IN_WIDTH+1){1'b1}}, {(IN_WIDTH-1){1'b0}}};

   always_comb begin
      conv     = shifted[IN_WIDTH-1:0];
      conv_sat = 1'b0;
      if (shifted > MAX_V) begin
         conv     = MAX_V[IN_WIDTH-1:0];
         conv_sat = 1'b1;
      end else if (shifted < MIN_V) begin
         conv     = MIN_V[IN_WIDTH-1:0];
         conv_sat = 1'b1;
      end
   end
`else
   // Wrap mode: bits above IN_WIDTH are discarded on purpose.
   logic unused_hi;
   assign unused_hi = ^shifted[EW-1:IN_WIDTH];
   assign conv      = shifted[IN_WIDTH-1:0];
   assign conv_sat  = 1'b0;
`endif

   // Vector as it will look after the current handshake: the incoming sample
   // replaces the element at the current fill position.
   generate
      for (genvar gi = 0; gi < INPUT_NUM; gi++) begin : g_vec
         assign vec_next[gi*IN_WIDTH +: IN_WIDTH] =
            (count == CNT_W'(gi)) ? conv : fill[gi];
      end
   endgenerate

   assign s_ready = (state == FILL);
   assign busy    = (state == ISSUE) || (state == WAIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= FILL;
         done_q <= 1'b0;
         x      <= '0;
         valid  <= 1'b0;
         count  <= '0;
         sat    <= 1'b0;
         for (int k = 0; k < INPUT_NUM; k++) begin
            fill[k] <= '0;
         end
      end else begin
         valid  <= 1'b0;
         sat    <= 1'b0;
         done_q <= layer_done;
         case (state)
            FILL: begin
               if (s_valid) begin
                  sat <= conv_sat;
                  for (int k = 0; k < INPUT_NUM; k++) begin
                     if (count == CNT_W'(k)) begin
                        fill[k] <= conv;
                     end
                  end
                  if (count == LAST) begin
                     x     <= vec_next;
                     count <= '0;
                     valid <= 1'b1;
                     state <= ISSUE;
                  end else begin
                     count <= count + CNT_W'(1);
                  end
               end
            end
            ISSUE: begin
               state <= WAIT;
            end
            WAIT: begin
               // Only a fresh rising edge releases the packer; a level held
               // high since before ISSUE belongs to the previous vector.
               if (layer_done && !done_q) begin
                  state <= FILL;
               end
            end
            default: begin
               state <= FILL;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_layer_input_packer.sv
module tb_layer_input_packer;

   localparam int N = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [23:0]   s_data = '0;
   logic [31:0]   x;
   logic          valid;
   logic          layer_done = 1'b0;
   logic [1:0]    count;
   logic          busy;
   logic          sat;

   layer_input_packer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .x          (x),
      .valid      (valid),
      .layer_done (layer_done),
      .count      (count),
      .busy       (busy),
      .sat        (sat)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

`ifdef LAYER_PACKER_SATURATE_EN
   localparam logic SAT_ON = 1'b1;
`else
   localparam logic SAT_ON = 1'b0;
`endif

   logic [31:0] exp_x_q [$];
   logic        exp_sat_q [$];
   logic [31:0] acc = '0;
   int          acc_n = 0;
   logic [31:0] last_x = '0;
   logic        hs_q = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected element for one accepted sample; a completed vector goes to the scoreboard.
   task automatic record(input logic [15:0] e, input logic s);
      exp_sat_q.push_back(s);
      acc[acc_n*16 +: 16] = e;
      acc_n++;
      if (acc_n == N) begin
         exp_x_q.push_back(acc);
         acc   = '0;
         acc_n = 0;
      end
   endtask

   task automatic send(input logic [23:0] d, input logic [15:0] e, input logic s);
      int w;
      w = 0;
      s_valid = 1'b1;
      s_data  = d;
      while (!s_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (!s_ready) begin
         total++;
         bad++;
         $display("FAIL send_timeout: s_ready got 0 expected 1");
         s_valid = 1'b0;
      end else begin
         record(e, s);
         @(posedge clk);
         #1;
         s_valid = 1'b0;
      end
   endtask

   // From just after the final handshake: ISSUE, WAIT, then a layer_done pulse.
   task automatic finish_vector();
      @(negedge clk);
      chk("valid_issue", valid, 1);
      @(negedge clk);
      chk("busy_wait", busy, 1);
      layer_done = 1'b1;
      @(negedge clk);
      layer_done = 1'b0;
      chk("ready_after_done", s_ready, 1);
   endtask

   // Monitor: handshakes and output vectors are matched against the scoreboard.
   always @(posedge clk) hs_q <= s_valid && s_ready && rst_n;

   always @(negedge clk) begin
      if (hs_q) begin
         if (exp_sat_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sat_underflow: got handshake expected none");
         end else begin
            chk("sat", sat, exp_sat_q.pop_front());
         end
      end else begin
         chk("sat_idle", sat, 0);
      end
      if (valid) begin
         if (exp_x_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL valid_unexpected: got valid with x=%0h expected none", x);
         end else begin
            chk("x", x, exp_x_q.pop_front());
         end
      end else if (rst_n) begin
         chk("x_hold", x, last_x);
      end
      last_x = x;
   end

   initial begin
      int n, last_v, done_at, nv;

      // Reset state
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_count", count, 0);
      chk("rst_x", x, 0);
      chk("rst_valid", valid, 0);
      chk("rst_ready", s_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_sat", sat, 0);

      // Reset mid-FILL discards the partial vector
      @(negedge clk);
      send(24'h010000, 16'h4000, 1'b0);
      @(negedge clk);
      chk("count_one", count, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_count", count, 0);
      chk("midrst_x", x, 0);
      chk("midrst_valid", valid, 0);
      acc   = '0;
      acc_n = 0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("midrst_ready", s_ready, 1);

      // 1.0 and -1.0 back-to-back; layer_done already high before ISSUE
      @(negedge clk);
      send(24'h010000, 16'h4000, 1'b0);
      chk("count_after_first", count, 1);
      layer_done = 1'b1;
      send(24'hFF0000, 16'hC000, 1'b0);
      @(negedge clk);
      chk("valid_pulse", valid, 1);
      chk("ready_issue", s_ready, 0);
      chk("x_expected", x, 32'hC000_4000);
      repeat (4) begin
         @(negedge clk);
         chk("hold_level_wait", s_ready, 0);
         chk("valid_low", valid, 0);
      end
      layer_done = 1'b0;
      @(negedge clk);
      chk("still_wait", s_ready, 0);
      layer_done = 1'b1;
      #1;
      chk("pre_edge_wait", s_ready, 0);
      @(negedge clk);
      chk("fill_after_rise", s_ready, 1);
      chk("x_unchanged", x, 32'hC000_4000);
      layer_done = 1'b0;

      // Saturate / wrap
      @(negedge clk);
      send(24'h030000, SAT_ON ? 16'h7FFF : 16'hC000, SAT_ON);
      send(24'hFD0000, SAT_ON ? 16'h8000 : 16'h4000, SAT_ON);
      finish_vector();

      // Floor truncation
      @(negedge clk);
      send(24'h000003, 16'h0000, 1'b0);
      send(24'hFFFFFF, 16'hFFFF, 1'b0);
      finish_vector();

      // Streaming with s_valid held high, layer_done pulsed 3 cycles after valid
      n = 1;
      last_v = -1;
      done_at = -1;
      nv = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge clk);
         if (valid) begin
            nv++;
            if (last_v >= 0) chk("valid_gap", 64'(cyc - last_v), 6);
            last_v = cyc;
            done_at = cyc + 3;
         end
         layer_done = (cyc == done_at);
         if (s_ready) begin
            if (n <= 8) begin
               s_valid = 1'b1;
               s_data  = 24'(n << 2);
               record(16'(n), 1'b0);
               n++;
            end else begin
               s_valid = 1'b0;
            end
         end
      end
      layer_done = 1'b0;
      s_valid = 1'b0;
      chk("stream_vectors", nv, 4);

      repeat (3) @(negedge clk);
      chk("x_queue_empty", exp_x_q.size(), 0);
      chk("sat_queue_empty", exp_sat_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
